// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and constants for the PWM blocks
package pwm_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;
endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: sequential restoring divider producing a DUTY_W-bit quotient
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W+DUTY_W-1:0]   num,
    input  logic [CNT_W-1:0]          den,
    output logic                      busy,
    output logic                      done,
    output logic [DUTY_W-1:0]         quot
);
    logic [CNT_W+DUTY_W-1:0] rem, dvs;
    logic [DUTY_W-1:0]       q;
    logic [2:0]              iter;
    logic                    bit_q;

    assign bit_q = rem >= dvs;

    // divisor starts aligned to the top quotient bit and shifts right once per cycle
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            dvs  <= '0;
            q    <= '0;
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            quot <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    rem  <= num;
                    dvs  <= {1'b0, den, (DUTY_W-1)'(0)};
                    iter <= 3'(DUTY_W - 1);
                    busy <= 1'b1;
                end
            end else begin
                rem  <= bit_q ? rem - dvs : rem;
                dvs  <= dvs >> 1;
                q    <= {q[DUTY_W-2:0], bit_q};
                iter <= iter - 3'd1;
                if (iter == 3'd0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    quot <= {q[DUTY_W-2:0], bit_q};
                end
            end
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of an incoming PWM pin
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 2400000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              meas_valid,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              duty_valid,
    output logic              stuck_high,
    output logic              stuck_low
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t            state, state_d;
    logic              s1, s2, s3, rise, fall;
    logic [CNT_W-1:0]  cnt, hi_tmp;
    logic              latch_hi, report, set_sh, set_sl, div_busy;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // synchronizer plus edge-detect delay flop
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) {s1, s2, s3} <= 3'b000;
        else     {s1, s2, s3} <= {pwm_in, s1, s2};
    end

    // cycle counter restarted by every rise, saturating at the timeout
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= rise ? CNT_W'(1) : (cnt < TMO ? cnt + CNT_W'(1) : cnt);
    end

    // state register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // next state and measurement events; rise wins over timeout
    always_comb begin
        state_d  = state;
        latch_hi = 1'b0;
        report   = 1'b0;
        set_sh   = 1'b0;
        set_sl   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_d = HIGH;
                else if (cnt == TMO && !s2 && !stuck_high && !stuck_low) set_sl = 1'b1;
            end
            HIGH: begin
                if (fall) begin
                    latch_hi = 1'b1;
                    state_d  = LOW;
                end else if (cnt == TMO) begin
                    set_sh  = 1'b1;
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    report  = 1'b1;
                    state_d = HIGH;
                end else if (cnt == TMO) begin
                    set_sl  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // result registers and stuck flags
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hi_tmp     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            hi_tmp     <= latch_hi ? cnt : hi_tmp;
            period     <= report ? cnt : period;
            high_time  <= report ? hi_tmp : high_time;
            meas_valid <= report;
            stuck_high <= rise ? 1'b0 : (set_sh ? 1'b1 : stuck_high);
            stuck_low  <= rise ? 1'b0 : (set_sl ? 1'b1 : stuck_low);
        end
    end

    pwm_duty_div #(.CNT_W(CNT_W)) u_div (
        .clk_in (clk_in),
        .rst    (rst),
        .start  (meas_valid),
        .num    ((CNT_W+DUTY_W)'(high_time) * (CNT_W+DUTY_W)'(PCT_SCALE)),
        .den    (period),
        .busy   (div_busy),
        .done   (duty_valid),
        .quot   (duty_pct)
    );
endmodule
